sipo_deser: RTL and testbench

Serial-in, parallel-out deserializer. It is the receiving end of the team's 4-bit PISO serial link.
- Collects qualified serial bits, LSB-first by default, into a WIDTH-bit word.
- Presents each completed word on a one-entry holding register with a valid/ready handshake.
- Flags words lost to back-pressure.
- Sits between a PISO-style serial source and any parallel consumer.

---
 rtl/sipo_deser_pkg.sv | 14 +
 rtl/sipo_shift_core.sv | 65 ++++++
 rtl/sipo_deser.sv | 84 ++++++++
 tb/tb_sipo_deser.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sipo_deser_pkg.sv
// Shared constants for the 4-bit PISO/SIPO serial link.
// Both ends import this so the word width stays in agreement.
package sipo_deser_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam int SER_WIDTH = 4;

    function automatic int cnt_bits(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register, bit counter and word-completion strobe.
// done_o/word_o are valid in the cycle the last bit is sampled.
module sipo_shift_core
    import sipo_deser_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH,
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             se_in,
    input  logic             se_vld,
    input  logic             clr,
    output logic             done_o,
    output logic [WIDTH-1:0] word_o,
    output logic             busy_o
);

    localparam int CW = cnt_bits(WIDTH);

    logic [WIDTH-1:0] sh_q, sh_d, shifted;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [0:0]       st_q, st_d;

    assign shifted = (LSB_FIRST != 0) ? {se_in, sh_q[WIDTH-1:1]}
                                      : {sh_q[WIDTH-2:0], se_in};

    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        st_d   = st_q;
        done_o = 1'b0;
        if (clr) begin
            sh_d  = '0;
            cnt_d = '0;
            st_d  = ST_IDLE;
        end else if (se_vld) begin
            sh_d = shifted;
            if (cnt_q == CW'(WIDTH - 1)) begin
                done_o = 1'b1;
                cnt_d  = '0;
                st_d   = ST_IDLE;
            end else begin
                cnt_d = cnt_q + CW'(1);
                st_d  = ST_SHIFT;
            end
        end
    end

    assign word_o = shifted;
    assign busy_o = (st_q == ST_SHIFT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_q  <= '0;
            cnt_q <= '0;
            st_q  <= ST_IDLE;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
            st_q  <= st_d;
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer with a one-entry output
// holding register, valid/ready handshake and sticky overrun.
module sipo_deser
    import sipo_deser_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH,
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             se_in,
    input  logic             se_vld,
    input  logic             clr,
    output logic [WIDTH-1:0] pa_out,
    output logic             pa_valid,
    input  logic             pa_ready,
    output logic             busy,
    output logic             overrun
);

    logic             done;
    logic [WIDTH-1:0] word;
    logic             busy_q;

    logic [WIDTH-1:0] pa_q, pa_d;
    logic             vld_q, vld_d;
    logic             ovr_q, ovr_d;
    logic             drain;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .se_in  (se_in),
        .se_vld (se_vld),
        .clr    (clr),
        .done_o (done),
        .word_o (word),
        .busy_o (busy_q)
    );

    assign drain = vld_q & pa_ready;

    // A completion may refill the slot on the same edge it drains.
    always_comb begin
        pa_d  = pa_q;
        vld_d = vld_q;
        ovr_d = ovr_q;
        if (drain) begin
            vld_d = 1'b0;
        end
        if (done) begin
            if (!vld_q || drain) begin
                pa_d  = word;
                vld_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
        if (clr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pa_q  <= '0;
            vld_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            pa_q  <= pa_d;
            vld_q <= vld_d;
            ovr_q <= ovr_d;
        end
    end

    assign pa_out   = pa_q;
    assign pa_valid = vld_q;
    assign overrun  = ovr_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: three instances cover
// LSB-first W4, MSB-first W4 and MSB-first W8.
module tb_sipo_deser;

    logic clk = 1'b0;
    logic rst;
    logic se_in, se_vld, clr, pa_ready;

    logic [3:0] a_out, b_out;
    logic [7:0] c_out;
    logic a_vld, a_busy, a_ovr;
    logic b_vld, b_busy, b_ovr;
    logic c_vld, c_busy, c_ovr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(4), .LSB_FIRST(1)) u_a (
        .clk(clk), .rst(rst), .se_in(se_in), .se_vld(se_vld),
        .clr(clr), .pa_out(a_out), .pa_valid(a_vld),
        .pa_ready(pa_ready), .busy(a_busy), .overrun(a_ovr)
    );

    sipo_deser #(.WIDTH(4), .LSB_FIRST(0)) u_b (
        .clk(clk), .rst(rst), .se_in(se_in), .se_vld(se_vld),
        .clr(clr), .pa_out(b_out), .pa_valid(b_vld),
        .pa_ready(pa_ready), .busy(b_busy), .overrun(b_ovr)
    );

    sipo_deser #(.WIDTH(8), .LSB_FIRST(0)) u_c (
        .clk(clk), .rst(rst), .se_in(se_in), .se_vld(se_vld),
        .clr(clr), .pa_out(c_out), .pa_valid(c_vld),
        .pa_ready(pa_ready), .busy(c_busy), .overrun(c_ovr)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic b);
        se_in  = b;
        se_vld = 1'b1;
        @(posedge clk);
        #1;
        se_vld = 1'b0;
        se_in  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic drain_once();
        pa_ready = 1'b1;
        @(posedge clk);
        #1;
        pa_ready = 1'b0;
    endtask

    logic [7:0] a5;

    initial begin
        rst = 1'b0; se_in = 1'b0; se_vld = 1'b0;
        clr = 1'b0; pa_ready = 1'b0;
        #2;
        chk("rst_out",  32'(a_out), 32'h0);
        chk("rst_vld",  32'(a_vld), 32'h0);
        chk("rst_busy", 32'(a_busy), 32'h0);
        chk("rst_ovr",  32'(a_ovr), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);

        // 1: basic word
        send(1'b0); chk("t1_busy1", 32'(a_busy), 32'h1);
        send(1'b1); chk("t1_busy2", 32'(a_busy), 32'h1);
        send(1'b0); chk("t1_busy3", 32'(a_busy), 32'h1);
        chk("t1_vld3", 32'(a_vld), 32'h0);
        send(1'b1);
        chk("t1_busy4", 32'(a_busy), 32'h0);
        chk("t1_vld",   32'(a_vld), 32'h1);
        chk("t1_out",   32'(a_out), 32'ha);

        // 2: gaps between bits
        drain_once();
        chk("t2_drain", 32'(a_vld), 32'h0);
        send(1'b0);
        send(1'b1);
        idle(2);
        chk("t2_gap_busy", 32'(a_busy), 32'h1);
        chk("t2_gap_vld",  32'(a_vld), 32'h0);
        send(1'b0);
        chk("t2_busy3", 32'(a_busy), 32'h1);
        send(1'b1);
        chk("t2_vld", 32'(a_vld), 32'h1);
        chk("t2_out", 32'(a_out), 32'ha);

        // 3: overrun while holding full
        send(1'b0); send(1'b1); send(1'b1); send(1'b0);
        chk("t3_out", 32'(a_out), 32'ha);
        chk("t3_vld", 32'(a_vld), 32'h1);
        chk("t3_ovr", 32'(a_ovr), 32'h1);
        drain_once();
        chk("t3_ovr_drain", 32'(a_ovr), 32'h1);
        send(1'b0); send(1'b1); send(1'b1); send(1'b0);
        chk("t3_refill", 32'(a_out), 32'h6);
        pulse_clr();
        chk("t3_clr_ovr", 32'(a_ovr), 32'h0);
        chk("t3_clr_vld", 32'(a_vld), 32'h1);
        chk("t3_clr_out", 32'(a_out), 32'h6);

        // 4: last bit coincides with drain
        drain_once();
        send(1'b1); send(1'b0); send(1'b1); send(1'b0);
        chk("t4_pre", 32'(a_out), 32'h5);
        send(1'b0); send(1'b1); send(1'b1);
        pa_ready = 1'b1;
        send(1'b0);
        pa_ready = 1'b0;
        chk("t4_out", 32'(a_out), 32'h6);
        chk("t4_vld", 32'(a_vld), 32'h1);
        chk("t4_ovr", 32'(a_ovr), 32'h0);

        // 5a: clr mid-word, sample on clr edge discarded
        drain_once();
        send(1'b1); send(1'b1);
        se_in = 1'b1; se_vld = 1'b1;
        pulse_clr();
        se_vld = 1'b0; se_in = 1'b0;
        chk("t5_clr_busy", 32'(a_busy), 32'h0);
        send(1'b1); send(1'b1); send(1'b0);
        chk("t5_nocomp", 32'(a_vld), 32'h0);
        send(1'b0);
        chk("t5_out", 32'(a_out), 32'h3);
        chk("t5_vld", 32'(a_vld), 32'h1);

        // 5b: async reset mid-word
        send(1'b1); send(1'b0); send(1'b1); send(1'b1);
        chk("t5b_ovr_pre", 32'(a_ovr), 32'h1);
        send(1'b1); send(1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("t5b_out",  32'(a_out), 32'h0);
        chk("t5b_vld",  32'(a_vld), 32'h0);
        chk("t5b_busy", 32'(a_busy), 32'h0);
        chk("t5b_ovr",  32'(a_ovr), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);

        // 6: MSB-first, W4 then W8 back-to-back
        send(1'b1); send(1'b0); send(1'b1); send(1'b0);
        chk("t6_b_out", 32'(b_out), 32'ha);
        chk("t6_b_vld", 32'(b_vld), 32'h1);
        chk("t6_c_busy", 32'(c_busy), 32'h1);
        drain_once();
        pulse_clr();
        pa_ready = 1'b1;
        a5 = 8'ha5;
        for (int i = 7; i >= 0; i--) send(a5[i]);
        pa_ready = 1'b1;
        chk("t6_c_out1", 32'(c_out), 32'ha5);
        chk("t6_c_vld1", 32'(c_vld), 32'h1);
        send(a5[7]);
        chk("t6_c_drn", 32'(c_vld), 32'h0);
        for (int i = 6; i >= 0; i--) send(a5[i]);
        pa_ready = 1'b1;
        chk("t6_c_out2", 32'(c_out), 32'ha5);
        chk("t6_c_vld2", 32'(c_vld), 32'h1);
        chk("t6_c_ovr",  32'(c_ovr), 32'h0);
        pa_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
